// File: rtl/mem_arbiter_51_if.sv
// Bus bundle for mem_arbiter_51: two requester ports, the shared memory port and status.
// master = requesters plus memory model, slave = the arbiter.
interface mem_arbiter_51_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              req0_51;
    logic              we0_51;
    logic [ADDR_W-1:0] addr0_51;
    logic [DATA_W-1:0] wdata0_51;
    logic              ack0_51;
    logic [DATA_W-1:0] rdata0_51;

    logic              req1_51;
    logic              we1_51;
    logic [ADDR_W-1:0] addr1_51;
    logic [DATA_W-1:0] wdata1_51;
    logic              ack1_51;
    logic [DATA_W-1:0] rdata1_51;

    logic [ADDR_W-1:0] mem_addr_51;
    logic [DATA_W-1:0] mem_wdata_51;
    logic              mem_we_51;
    logic [DATA_W-1:0] mem_rdata_51;

    logic              busy_51;
    logic [CNT_W-1:0]  cnt0_51;
    logic [CNT_W-1:0]  cnt1_51;

    modport master (
        output req0_51, we0_51, addr0_51, wdata0_51,
        output req1_51, we1_51, addr1_51, wdata1_51,
        output mem_rdata_51,
        input  ack0_51, rdata0_51, ack1_51, rdata1_51,
        input  mem_addr_51, mem_wdata_51, mem_we_51,
        input  busy_51, cnt0_51, cnt1_51
    );

    modport slave (
        input  req0_51, we0_51, addr0_51, wdata0_51,
        input  req1_51, we1_51, addr1_51, wdata1_51,
        input  mem_rdata_51,
        output ack0_51, rdata0_51, ack1_51, rdata1_51,
        output mem_addr_51, mem_wdata_51, mem_we_51,
        output busy_51, cnt0_51, cnt1_51
    );
endinterface

// File: rtl/mem_arbiter_51.sv
// Two-port arbiter in front of a single-ported word memory: serialises accesses,
// registers read data, pulses a one-cycle ack per access and counts grants per port.
module mem_arbiter_51 #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FIXED_PRI = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic            clk_51,
    input  logic            rst_51,
    mem_arbiter_51_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic              rr_ptr;
    logic              id_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              mem_we_q;
    logic              busy_q;
    logic [CNT_W-1:0]  cnt0_q;
    logic [CNT_W-1:0]  cnt1_q;

    logic              grant;
    logic              win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // In RESP only the port that was not just acked may be granted.
    always_comb begin
        grant = 1'b0;
        win   = 1'b0;
        if (state == IDLE) begin
            grant = bus.req0_51 | bus.req1_51;
            if (bus.req0_51 && bus.req1_51)
                win = (FIXED_PRI != 0) ? 1'b0 : rr_ptr;
            else
                win = bus.req1_51;
        end else if (state == RESP) begin
            win   = ~id_q;
            grant = id_q ? bus.req0_51 : bus.req1_51;
        end
        sel_we    = win ? bus.we1_51    : bus.we0_51;
        sel_addr  = win ? bus.addr1_51  : bus.addr0_51;
        sel_wdata = win ? bus.wdata1_51 : bus.wdata0_51;
    end

    always_ff @(posedge clk_51 or posedge rst_51) begin
        if (rst_51) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (state == RESP) begin
                        if (!id_q && cnt0_q != '1) cnt0_q <= cnt0_q + CNT_W'(1);
                        if ( id_q && cnt1_q != '1) cnt1_q <= cnt1_q + CNT_W'(1);
                    end
                    if (grant) begin
                        id_q     <= win;
                        rr_ptr   <= ~win;
                        we_q     <= sel_we;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        mem_we_q <= sel_we;
                        busy_q   <= 1'b1;
                        state    <= ACCESS;
                    end else begin
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (id_q) rdata1_q <= bus.mem_rdata_51;
                        else      rdata0_q <= bus.mem_rdata_51;
                    end
                    mem_we_q <= 1'b0;
                    ack0_q   <= ~id_q;
                    ack1_q   <= id_q;
                    state    <= RESP;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr_51  = addr_q;
    assign bus.mem_wdata_51 = wdata_q;
    assign bus.mem_we_51    = mem_we_q;
    assign bus.ack0_51      = ack0_q;
    assign bus.ack1_51      = ack1_q;
    assign bus.rdata0_51    = rdata0_q;
    assign bus.rdata1_51    = rdata1_q;
    assign bus.busy_51      = busy_q;
    assign bus.cnt0_51      = cnt0_q;
    assign bus.cnt1_51      = cnt1_q;
endmodule
